coco_ps2key_matrix: RTL

//  Converts MiSTer hps_io ps2_key events into the CoCo 3 7x8 keyboard matrix read by PIA0.

---
 rtl/coco_ps2key_matrix.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/coco_ps2key_matrix.sv
// -----------------------------------------------------------------------------
// coco_ps2key_matrix
//   Turns MiSTer hps_io ps2_key events (scan code set 2) into the CoCo 3 7x8
//   keyboard matrix that PIA0 scans. It tracks press/release state per mapped
//   key, answers column strobes with registered row data, and keeps a freshly
//   pressed key asserted for at least MIN_PRESS_CYCLES so a BASIC scan loop
//   cannot miss a short tap.
//
// Ports
//   clk_sys      in   system clock (sole clock)
//   reset        in   synchronous, active-high; clears all key state
//   ps2_key      in   [7:0] code, [8] E0-extended, [9] 1=press, [10] event toggle
//   col_strobe_n in   PIA0 port B column drive, active low
//   row_n        out  PIA0 port A rows [6:0], active low, registered
//   key_event    out  one-cycle pulse when a mapped key changes state
//   any_key      out  high while any key bit is set (stretched keys included)
//
// Pipeline: C0 event latch, C1 registered map lookup, C2 key state update and
// key_event, C3 row_n.
// -----------------------------------------------------------------------------
module coco_ps2key_matrix #(
    parameter int unsigned MIN_PRESS_CYCLES = 2_000_000,
    parameter bit          EXT_ARROWS       = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  col_strobe_n,
    output logic [6:0]  row_n,
    output logic        key_event,
    output logic        any_key
);

    localparam int unsigned    CNT_W     = $clog2(MIN_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_PRESS_CYCLES - 1);

    // Hold slot: EMPTY (no stretched key), HELD (key in slot and down),
    // PEND (released by the keyboard, kept asserted until the counter expires).
    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_HELD,
        SLOT_PEND
    } slot_t;

    // ---------------------------------------------------------------- C0
    logic       prev_toggle;
    logic       ev_valid;
    logic       ev_ext;
    logic       ev_press;
    logic [7:0] ev_code;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Loading the current toggle means the first cycle after reset
            // can never be mistaken for an event.
            prev_toggle <= ps2_key[10];
            ev_valid    <= 1'b0;
            ev_ext      <= 1'b0;
            ev_press    <= 1'b0;
            ev_code     <= '0;
        end else begin
            prev_toggle <= ps2_key[10];
            ev_valid    <= (ps2_key[10] != prev_toggle);
            if (ps2_key[10] != prev_toggle) begin
                ev_ext   <= ps2_key[8];
                ev_press <= ps2_key[9];
                ev_code  <= ps2_key[7:0];
            end
        end
    end

    // ---------------------------------------------------------------- C1
    // Result is {valid, row[2:0], col[2:0]} written as 7'o1RC. Row 7 col 7 is
    // not a matrix position: it holds right shift, ORed into SHIFT (r6 c7).
    function automatic logic [6:0] map_code(input logic ext, input logic [7:0] code);
        logic [6:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                8'h52: m = 7'o100;  // '  -> @
                8'h1C: m = 7'o101;  // A
                8'h32: m = 7'o102;  // B
                8'h21: m = 7'o103;  // C
                8'h23: m = 7'o104;  // D
                8'h24: m = 7'o105;  // E
                8'h2B: m = 7'o106;  // F
                8'h34: m = 7'o107;  // G
                8'h33: m = 7'o110;  // H
                8'h43: m = 7'o111;  // I
                8'h3B: m = 7'o112;  // J
                8'h42: m = 7'o113;  // K
                8'h4B: m = 7'o114;  // L
                8'h3A: m = 7'o115;  // M
                8'h31: m = 7'o116;  // N
                8'h44: m = 7'o117;  // O
                8'h4D: m = 7'o120;  // P
                8'h15: m = 7'o121;  // Q
                8'h2D: m = 7'o122;  // R
                8'h1B: m = 7'o123;  // S
                8'h2C: m = 7'o124;  // T
                8'h3C: m = 7'o125;  // U
                8'h2A: m = 7'o126;  // V
                8'h1D: m = 7'o127;  // W
                8'h22: m = 7'o130;  // X
                8'h35: m = 7'o131;  // Y
                8'h1A: m = 7'o132;  // Z
                8'h29: m = 7'o137;  // SPACE
                8'h45: m = 7'o140;  // 0
                8'h16: m = 7'o141;  // 1
                8'h1E: m = 7'o142;  // 2
                8'h26: m = 7'o143;  // 3
                8'h25: m = 7'o144;  // 4
                8'h2E: m = 7'o145;  // 5
                8'h36: m = 7'o146;  // 6
                8'h3D: m = 7'o147;  // 7
                8'h3E: m = 7'o150;  // 8
                8'h46: m = 7'o151;  // 9
                8'h55: m = 7'o152;  // =  -> :
                8'h4C: m = 7'o153;  // ;
                8'h41: m = 7'o154;  // ,
                8'h4E: m = 7'o155;  // -
                8'h49: m = 7'o156;  // .
                8'h4A: m = 7'o157;  // /
                8'h5A: m = 7'o160;  // ENTER
                8'h76: m = 7'o162;  // ESC   -> BREAK
                8'h11: m = 7'o163;  // LALT  -> ALT
                8'h14: m = 7'o164;  // LCTRL -> CTRL
                8'h05: m = 7'o165;  // F1
                8'h06: m = 7'o166;  // F2
                8'h12: m = 7'o167;  // LSHIFT
                8'h59: m = 7'o177;  // RSHIFT (second SHIFT bit)
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h6C: m = 7'o161;  // HOME -> CLEAR
                8'h75: m = EXT_ARROWS ? 7'o133 : 7'o000;  // UP
                8'h72: m = EXT_ARROWS ? 7'o134 : 7'o000;  // DOWN
                8'h6B: m = EXT_ARROWS ? 7'o135 : 7'o000;  // LEFT
                8'h74: m = EXT_ARROWS ? 7'o136 : 7'o000;  // RIGHT
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    logic [6:0] lookup;
    logic       map_valid;
    logic       map_press;
    logic [5:0] map_idx;

    assign lookup = map_code(ev_ext, ev_code);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            map_valid <= 1'b0;
            map_press <= 1'b0;
            map_idx   <= '0;
        end else begin
            map_valid <= ev_valid && lookup[6];
            map_press <= ev_press;
            map_idx   <= lookup[5:0];
        end
    end

    // ---------------------------------------------------------------- C2
    logic [63:0]      key_bits, key_next;
    logic [CNT_W-1:0] hold_cnt, cnt_next;
    logic [5:0]       hold_key, hold_key_next;
    slot_t            slot, slot_next;
    logic             event_next;
    logic             expire;

    always_comb begin
        key_next      = key_bits;
        cnt_next      = (hold_cnt != '0) ? hold_cnt - CNT_W'(1) : '0;
        hold_key_next = hold_key;
        slot_next     = slot;
        event_next    = 1'b0;
        expire        = (slot == SLOT_PEND) && (hold_cnt == '0);

        if (map_valid && map_press) begin
            // Another key arriving while a release is pending retires that
            // release right now, so the slot can be handed over in one cycle.
            if ((slot == SLOT_PEND) && (hold_key != map_idx)) begin
                key_next[hold_key] = 1'b0;
                event_next         = 1'b1;
            end
            if (!key_bits[map_idx]) begin
                key_next[map_idx] = 1'b1;
                event_next        = 1'b1;
            end
            cnt_next      = HOLD_LOAD;
            hold_key_next = map_idx;
            slot_next     = SLOT_HELD;
        end else if (map_valid) begin
            if ((slot != SLOT_EMPTY) && (hold_key == map_idx)) begin
                if ((slot == SLOT_HELD) && key_bits[map_idx]) begin
                    if (hold_cnt != '0) begin
                        slot_next = SLOT_PEND;
                    end else begin
                        key_next[map_idx] = 1'b0;
                        event_next        = 1'b1;
                        slot_next         = SLOT_EMPTY;
                    end
                end else if (expire) begin
                    key_next[hold_key] = 1'b0;
                    event_next         = 1'b1;
                    slot_next          = SLOT_EMPTY;
                end
            end else begin
                if (key_bits[map_idx]) begin
                    key_next[map_idx] = 1'b0;
                    event_next        = 1'b1;
                end
                if (expire) begin
                    key_next[hold_key] = 1'b0;
                    event_next         = 1'b1;
                    slot_next          = SLOT_EMPTY;
                end
            end
        end else if (expire) begin
            key_next[hold_key] = 1'b0;
            event_next         = 1'b1;
            slot_next          = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_bits  <= '0;
            hold_cnt  <= '0;
            hold_key  <= '0;
            slot      <= SLOT_EMPTY;
            key_event <= 1'b0;
        end else begin
            key_bits  <= key_next;
            hold_cnt  <= cnt_next;
            hold_key  <= hold_key_next;
            slot      <= slot_next;
            key_event <= event_next;
        end
    end

    // Bits 56..62 are never set; only bit 63 (right shift) lives above row 6.
    assign any_key = |key_bits;

    // ---------------------------------------------------------------- C3
    logic [7:0] mrow [7];
    logic [6:0] row_next;

    always_comb begin
        for (int unsigned r = 0; r < 6; r++) begin
            mrow[r] = key_bits[r*8 +: 8];
        end
        mrow[6] = {key_bits[55] | key_bits[63], key_bits[54:48]};
        row_next = '1;
        for (int unsigned r = 0; r < 7; r++) begin
            row_next[r] = ~|(mrow[r] & ~col_strobe_n);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            row_n <= '1;
        end else begin
            row_n <= row_next;
        end
    end

endmodule
